pagerank_gather: RTL
====================

// Module: pagerank_gather
// PURPOSE
//  Gather stage of one PageRank iteration, directly downstream of the scatter stage.
//  - Accumulates every scatter contribution (value, node_id) into a per-node Q32.32 sum.
//  - After scatter signals completion, applies damping: pr_new[k] = BASE_Q + (DAMP_Q*acc[k])>>FRAC_W.
//  - Streams the new rank for each node of the partition, in node order, to the next iteration.
// PARAMETERS
//  NODES_IN_PARTITION  4           number of nodes; legal node_id range is 0..NODES_IN_PARTITION-1
//  FRAC_W              32          fraction bits of the 64-bit unsigned fixed-point rank format
//  DAMP_Q              3650722202  damping factor d=0.85 as a 32-bit unsigned value with FRAC_W fraction bits
//  BASE_Q              161061274   teleport term (1-d)/NODES_IN_PARTITION in Q32.32
// PORTS
//  clock               in   1   single clock; all state updates on posedge
//  reset_n             in   1   asynchronous, active-low reset
//  gather_enable       in   1   level; starts an iteration from IDLE, releases DONE when low
//  pagerank_scatter    in   64  scatter contribution, Q32.32 unsigned
//  node_id             in   32  destination node of pagerank_scatter
//  output_ready        in   1   valid strobe for pagerank_scatter/node_id; no backpressure exists
//  operation_complete  in   1   level from scatter: all contributions have been sent
//  pagerank_new        out  64  new rank, Q32.32
//  new_node_id         out  32  node index of pagerank_new
//  new_valid           out  1   pagerank_new/new_node_id valid this cycle
//  iteration_done      out  1   level; high in DONE
//  err_bad_id          out  1   sticky; a contribution arrived with node_id >= NODES_IN_PARTITION
//  err_overflow        out  1   sticky; an accumulator or result saturated
// BEHAVIOUR
//  Reset: state=IDLE; acc[*]=0; apply counter=0; every output = 0. Reset mid-iteration aborts it with no partial output.
//  States: IDLE -> ACCUM -> APPLY -> DONE -> IDLE.
//   IDLE : when gather_enable=1, clear acc[*] and both sticky errors, then go to ACCUM. Inputs in IDLE are ignored.
//   ACCUM: each cycle with output_ready=1 and a legal node_id: acc[node_id] <= sat64(acc[node_id]+pagerank_scatter).
//          Illegal node_id: drop the sample and set err_bad_id.
//          When operation_complete=1, go to APPLY. A sample valid in that same cycle is still accumulated first.
//   APPLY: counter k runs 0..NODES_IN_PARTITION-1, one node per cycle.
//          Compute the 96-bit product DAMP_Q*acc[k], shift right by FRAC_W, add BASE_Q, saturate to 64 bits.
//          Registered output: new_valid=1 with new_node_id=k in the cycle after APPLY step k.
//          new_valid is high for exactly NODES_IN_PARTITION consecutive cycles, with no gaps.
//          Input strobes in APPLY are ignored.
//          After the last step, go to DONE; the final new_valid beat coincides with the first DONE cycle.
//   DONE : iteration_done=1; hold until gather_enable=0, then go to IDLE.
//          acc[*] is retained until the next start.
//  Saturation: any sum or result above 2^64-1 clamps to 64'hFFFF_FFFF_FFFF_FFFF and sets err_overflow.
//  new_valid=0 -> pagerank_new=0 and new_node_id=0.
//  Latency: operation_complete sampled at edge E -> first new_valid in the cycle after E+1.
//  Sticky errors clear only on reset or on a new start from IDLE.
// TESTING
//  1. Basic: start; 2 strobes {node 1, 0x8000_0000}, then operation_complete ->
//     node1 = 3811783476; nodes 0, 2, 3 = 161061274; 4 contiguous new_valid beats with ids 0..3.
//  2. Same-cycle completion: last strobe {node 3, 0x1_0000_0000} arrives with operation_complete=1 ->
//     node3 = 3811783476; the sample is not lost.
//  3. Bad id: strobe {node 7, 0x1_0000_0000} -> err_bad_id=1; all four outputs = 161061274; no overflow flag.
//  4. Saturation: 2 strobes {node 0, 64'hFFFF_FFFF_FFFF_FFFF} -> acc0 clamps and err_overflow=1;
//     node0 = 64'hD999_999A_0000_0000 - 1 + 161061274.
//  5. Reset mid-ACCUM: drop reset_n for 1 ns between clock edges ->
//     outputs 0 immediately; restart with no strobes gives all nodes = 161061274.
//  6. Handshake: hold gather_enable high after DONE -> iteration_done stays 1 and no new beats appear;
//     drop gather_enable, re-raise -> fresh iteration with cleared acc.

Source files
------------

// File: rtl/pagerank_gather_if.sv
// Handshake and result signals between scatter, gather and the next iteration.
interface pagerank_gather_if;
    logic        gather_enable;
    logic [63:0] pagerank_scatter;
    logic [31:0] node_id;
    logic        output_ready;
    logic        operation_complete;
    logic [63:0] pagerank_new;
    logic [31:0] new_node_id;
    logic        new_valid;
    logic        iteration_done;
    logic        err_bad_id;
    logic        err_overflow;

    modport master (
        output gather_enable, pagerank_scatter, node_id, output_ready, operation_complete,
        input  pagerank_new, new_node_id, new_valid, iteration_done, err_bad_id, err_overflow
    );

    modport slave (
        input  gather_enable, pagerank_scatter, node_id, output_ready, operation_complete,
        output pagerank_new, new_node_id, new_valid, iteration_done, err_bad_id, err_overflow
    );
endinterface

// File: rtl/pagerank_gather.sv
// PageRank gather: accumulates scatter contributions per node, then streams
// damped ranks pr = BASE_Q + (DAMP_Q*acc)>>FRAC_W in node order.
//
// state | meaning
// IDLE  | waiting for gather_enable; start clears accumulators and errors
// ACCUM | summing contributions until operation_complete
// APPLY | one node per cycle through the damping datapath
// DONE  | iteration_done high until gather_enable drops
module pagerank_gather #(
    parameter int          NODES_IN_PARTITION = 4,
    parameter int          FRAC_W             = 32,
    parameter logic [31:0] DAMP_Q             = 32'd3650722202,
    parameter logic [63:0] BASE_Q             = 64'd161061274
) (
    input logic               clock,
    input logic               reset_n,
    pagerank_gather_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, APPLY, DONE} state_t;

    localparam int            CW   = (NODES_IN_PARTITION > 1) ? $clog2(NODES_IN_PARTITION) : 1;
    localparam logic [CW-1:0] LAST = CW'(NODES_IN_PARTITION - 1);

    state_t        state, state_nxt;
    logic [63:0]   acc [NODES_IN_PARTITION];
    logic [CW-1:0] cnt;
    logic [63:0]   pr_q;
    logic [31:0]   id_q;
    logic          valid_q;
    logic          bad_id_q;
    logic          ovf_q;

    logic          id_ok;
    logic [CW-1:0] id_idx;
    logic [64:0]   acc_sum;
    logic [95:0]   prod;
    logic [95:0]   prod_sh;
    logic [64:0]   res_sum;
    logic          res_ovf;
    logic [63:0]   res_sat;

    assign id_ok   = bus.node_id < 32'(NODES_IN_PARTITION);
    assign id_idx  = bus.node_id[CW-1:0];
    assign acc_sum = {1'b0, acc[id_idx]} + {1'b0, bus.pagerank_scatter};

    // Full-width product so the shifted term cannot silently wrap.
    assign prod    = 96'(DAMP_Q) * 96'(acc[cnt]);
    assign prod_sh = prod >> FRAC_W;
    assign res_sum = {1'b0, prod_sh[63:0]} + {1'b0, BASE_Q};
    assign res_ovf = (prod_sh[95:64] != 32'd0) || res_sum[64];
    assign res_sat = res_ovf ? 64'hFFFF_FFFF_FFFF_FFFF : res_sum[63:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.gather_enable)      state_nxt = ACCUM;
            ACCUM:   if (bus.operation_complete) state_nxt = APPLY;
            APPLY:   if (cnt == LAST)            state_nxt = DONE;
            DONE:    if (!bus.gather_enable)     state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NODES_IN_PARTITION; i++) acc[i] <= '0;
            cnt      <= '0;
            pr_q     <= '0;
            id_q     <= '0;
            valid_q  <= 1'b0;
            bad_id_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            pr_q    <= '0;
            id_q    <= '0;
            case (state)
                IDLE: begin
                    if (bus.gather_enable) begin
                        for (int i = 0; i < NODES_IN_PARTITION; i++) acc[i] <= '0;
                        cnt      <= '0;
                        bad_id_q <= 1'b0;
                        ovf_q    <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (bus.output_ready) begin
                        if (id_ok) begin
                            acc[id_idx] <= acc_sum[64] ? 64'hFFFF_FFFF_FFFF_FFFF : acc_sum[63:0];
                            if (acc_sum[64]) ovf_q <= 1'b1;
                        end else begin
                            bad_id_q <= 1'b1;
                        end
                    end
                end
                APPLY: begin
                    valid_q <= 1'b1;
                    pr_q    <= res_sat;
                    id_q    <= 32'(cnt);
                    if (res_ovf) ovf_q <= 1'b1;
                    cnt     <= (cnt == LAST) ? '0 : cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.pagerank_new   = pr_q;
    assign bus.new_node_id    = id_q;
    assign bus.new_valid      = valid_q;
    assign bus.iteration_done = (state == DONE);
    assign bus.err_bad_id     = bad_id_q;
    assign bus.err_overflow   = ovf_q;
endmodule
